// File: rtl/tracker_pkg.sv
// Shared types and constants for the red-ball frame sequencer.
// Coordinates, FSM states, threshold selects and bounds.
package tracker_pkg;

  typedef logic [15:0] coord_t;

  typedef enum logic [1:0] {
    ST_LIVE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FROZEN  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_CR_LOW  = 2'd0;
  localparam logic [1:0] SEL_CR_HIGH = 2'd1;
  localparam logic [1:0] SEL_CB_LOW  = 2'd2;
  localparam logic [1:0] SEL_CB_HIGH = 2'd3;

  localparam coord_t      H_ACTIVE = 16'd640;
  localparam coord_t      V_ACTIVE = 16'd480;
  localparam logic [16:0] JUMP_MAX = 17'd64;

  localparam logic [7:0] CR_LOW_RST  = 8'd140;
  localparam logic [7:0] CR_HIGH_RST = 8'd255;
  localparam logic [7:0] CB_LOW_RST  = 8'd0;
  localparam logic [7:0] CB_HIGH_RST = 8'd120;

  // |a - b| using a 17-bit signed difference.
  function automatic logic [16:0] abs_diff(
    input coord_t a,
    input coord_t b
  );
    logic signed [16:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[16] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Frame edge detector: registers the VGA vertical request and flags
// its rising (frame start) and falling (frame end) edges.
// Ports: clk_i, rst_i (sync, high), vreq_i -> start_o, end_o.
module frame_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vreq_i,
  output logic start_o,
  output logic end_o
);

  logic vreq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) vreq_q <= 1'b0;
    else       vreq_q <= vreq_i;
  end

  assign start_o = vreq_i & ~vreq_q;
  assign end_o   = ~vreq_i & vreq_q;

endmodule

// File: rtl/ball_tracker_ctrl.sv
// Frame-level sequencer for ball detection: snapshot/freeze FSM,
// frame-synchronous thresholds, centre latch and qualification.
// Ports: iVgaClk, reset (sync, high), iVgaVRequest, iSnapReq,
//   iRelease, iThreshWrEn/Sel/Data, iRedPixelH/VIndex ->
//   oFreezeRam, oCrLow/High, oCbLow/High, oCenterRow/Col,
//   oCenterValid, oFramePulse, oFrameCount, oBusy.
// Build option: TRACKER_SMOOTH_EN enables centre smoothing.
module ball_tracker_ctrl
  import tracker_pkg::*;
(
  input  logic        iVgaClk,
  input  logic        reset,
  input  logic        iVgaVRequest,
  input  logic        iSnapReq,
  input  logic        iRelease,
  input  logic        iThreshWrEn,
  input  logic [1:0]  iThreshSel,
  input  logic [7:0]  iThreshData,
  input  logic [15:0] iRedPixelHIndex,
  input  logic [15:0] iRedPixelVIndex,
  output logic        oFreezeRam,
  output logic [7:0]  oCrLow,
  output logic [7:0]  oCrHigh,
  output logic [7:0]  oCbLow,
  output logic [7:0]  oCbHigh,
  output logic [15:0] oCenterRow,
  output logic [15:0] oCenterCol,
  output logic        oCenterValid,
  output logic        oFramePulse,
  output logic [15:0] oFrameCount,
  output logic        oBusy
);

  localparam logic [3:0][7:0] THR_RST = {
    CB_HIGH_RST, CB_LOW_RST, CR_HIGH_RST, CR_LOW_RST
  };

  logic fs, fe;

  frame_edge_det u_edge (
    .clk_i   (iVgaClk),
    .rst_i   (reset),
    .vreq_i  (iVgaVRequest),
    .start_o (fs),
    .end_o   (fe)
  );

  state_e state_q, state_d;
  logic   rel_q, rel_d;
  logic   freeze_q, busy_q;

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    unique case (state_q)
      ST_LIVE:    if (iSnapReq) state_d = ST_ARMED;
      ST_ARMED:   if (fs) state_d = ST_CAPTURE;
      ST_CAPTURE: if (fe) state_d = ST_FROZEN;
      ST_FROZEN: begin
        // A release in the same cycle as frame_start counts.
        if (fs && (iRelease || rel_q)) begin
          state_d = ST_LIVE;
          rel_d   = 1'b0;
        end else if (iRelease) begin
          rel_d = 1'b1;
        end
      end
      default: state_d = ST_LIVE;
    endcase
  end

  always_ff @(posedge iVgaClk) begin
    if (reset) begin
      state_q  <= ST_LIVE;
      rel_q    <= 1'b0;
      freeze_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rel_q    <= rel_d;
      freeze_q <= (state_d == ST_FROZEN);
      busy_q   <= (state_d == ST_ARMED) ||
                  (state_d == ST_CAPTURE);
    end
  end

  // Shadow writes and active loads share an edge; the active
  // copy takes the pre-write shadow value.
  logic [3:0][7:0] shd_q, act_q;

  always_ff @(posedge iVgaClk) begin
    if (reset) begin
      shd_q <= THR_RST;
      act_q <= THR_RST;
    end else begin
      if (fe) act_q <= shd_q;
      if (iThreshWrEn) shd_q[iThreshSel] <= iThreshData;
    end
  end

  coord_t      prow_q, pcol_q;
  logic        first_q;
  coord_t      row_q, col_q, row_d, col_d;
  logic        valid_q, valid_d;
  logic [16:0] drow, dcol;
  logic        in_bounds;

  assign drow = abs_diff(iRedPixelHIndex, prow_q);
  assign dcol = abs_diff(iRedPixelVIndex, pcol_q);

  assign in_bounds = (iRedPixelVIndex < H_ACTIVE) &&
                     (iRedPixelHIndex < V_ACTIVE);

`ifdef TRACKER_SMOOTH_EN
  logic [17:0] sm_row, sm_col;
  assign sm_row = ({2'b00, row_q} << 1) + {2'b00, row_q} +
                  {2'b00, iRedPixelHIndex};
  assign sm_col = ({2'b00, col_q} << 1) + {2'b00, col_q} +
                  {2'b00, iRedPixelVIndex};
`endif

  always_comb begin
    valid_d = in_bounds &&
              (first_q || ((drow <= JUMP_MAX) &&
                           (dcol <= JUMP_MAX)));
    row_d = iRedPixelHIndex;
    col_d = iRedPixelVIndex;
`ifdef TRACKER_SMOOTH_EN
    if (!valid_d) begin
      row_d = row_q;
      col_d = col_q;
    end else if (valid_q) begin
      row_d = sm_row[17:2];
      col_d = sm_col[17:2];
    end
`endif
  end

  logic        pulse_q;
  logic [15:0] cnt_q;

  always_ff @(posedge iVgaClk) begin
    if (reset) begin
      prow_q  <= '0;
      pcol_q  <= '0;
      first_q <= 1'b1;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= fe;
      if (fe) begin
        prow_q  <= iRedPixelHIndex;
        pcol_q  <= iRedPixelVIndex;
        first_q <= 1'b0;
        row_q   <= row_d;
        col_q   <= col_d;
        valid_q <= valid_d;
        cnt_q   <= cnt_q + 16'd1;
      end
    end
  end

  assign oFreezeRam   = freeze_q;
  assign oBusy        = busy_q;
  assign oCrLow       = act_q[SEL_CR_LOW];
  assign oCrHigh      = act_q[SEL_CR_HIGH];
  assign oCbLow       = act_q[SEL_CB_LOW];
  assign oCbHigh      = act_q[SEL_CB_HIGH];
  assign oCenterRow   = row_q;
  assign oCenterCol   = col_q;
  assign oCenterValid = valid_q;
  assign oFramePulse  = pulse_q;
  assign oFrameCount  = cnt_q;

endmodule

// File: tb/tb_ball_tracker_ctrl.sv
// Self-checking bench for ball_tracker_ctrl.
// Short synthetic frames; frame-level reference model.
module tb_ball_tracker_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vreq = 1'b0;
  logic        snap = 1'b0;
  logic        rel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [7:0]  wdata = 8'd0;
  logic [15:0] hidx = 16'd0;
  logic [15:0] vidx = 16'd0;
  logic        freeze, valid, pulse, busy;
  logic [7:0]  crl, crh, cbl, cbh;
  logic [15:0] crow, ccol, fcnt;

  always #5 clk = ~clk;

  ball_tracker_ctrl dut (
    .iVgaClk         (clk),
    .reset           (reset),
    .iVgaVRequest    (vreq),
    .iSnapReq        (snap),
    .iRelease        (rel),
    .iThreshWrEn     (we),
    .iThreshSel      (sel),
    .iThreshData     (wdata),
    .iRedPixelHIndex (hidx),
    .iRedPixelVIndex (vidx),
    .oFreezeRam      (freeze),
    .oCrLow          (crl),
    .oCrHigh         (crh),
    .oCbLow          (cbl),
    .oCbHigh         (cbh),
    .oCenterRow      (crow),
    .oCenterCol      (ccol),
    .oCenterValid    (valid),
    .oFramePulse     (pulse),
    .oFrameCount     (fcnt),
    .oBusy           (busy)
  );

  int checks = 0;
  int errors = 0;

  int sh_m[4];
  int act_m[4];
  int cnt_m;
  int prow_m, pcol_m;
  bit first_m;
  bit vld_m;
  int crow_m, ccol_m;
  int pulses_m = 0;
  int pulses_seen = 0;

  always @(negedge clk) if (pulse === 1'b1) pulses_seen++;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sh_m    = '{140, 255, 0, 120};
    act_m   = '{140, 255, 0, 120};
    cnt_m   = 0;
    prow_m  = 0;
    pcol_m  = 0;
    first_m = 1;
    vld_m   = 0;
    crow_m  = 0;
    ccol_m  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    vreq  = 1'b0;
    snap  = 1'b0;
    rel   = 1'b0;
    we    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    vreq = 1'b1;
    @(negedge clk);
  endtask

  task automatic thr_write(int s, int d);
    @(negedge clk);
    we = 1'b1;
    sel = 2'(s);
    wdata = 8'(d);
    @(negedge clk);
    we = 1'b0;
    sh_m[s] = d;
  endtask

  task automatic frame_finish(int row, int col,
                              bit wr, int s, int d);
    int  dr, dc;
    bit  v;
    @(negedge clk);
    hidx = 16'(row);
    vidx = 16'(col);
    vreq = 1'b0;
    we   = wr;
    sel  = 2'(s);
    wdata = 8'(d);
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
    if (wr) sh_m[s] = d;
    dr = row - prow_m;
    dc = col - pcol_m;
    if (dr < 0) dr = -dr;
    if (dc < 0) dc = -dc;
    v = (col < 640) && (row < 480) &&
        (first_m || (dr <= 64 && dc <= 64));
`ifdef TRACKER_SMOOTH_EN
    if (v) begin
      if (vld_m) begin
        crow_m = (3 * crow_m + row) >> 2;
        ccol_m = (3 * ccol_m + col) >> 2;
      end else begin
        crow_m = row;
        ccol_m = col;
      end
    end
`else
    crow_m = row;
    ccol_m = col;
`endif
    vld_m   = v;
    prow_m  = row;
    pcol_m  = col;
    first_m = 0;
    cnt_m   = (cnt_m + 1) & 16'hFFFF;
    pulses_m++;
    chk("pulse", pulse, 1);
    chk("count", fcnt, cnt_m);
    chk("crlow", crl, act_m[0]);
    chk("crhigh", crh, act_m[1]);
    chk("cblow", cbl, act_m[2]);
    chk("cbhigh", cbh, act_m[3]);
    chk("row", crow, crow_m);
    chk("col", ccol, ccol_m);
    chk("valid", valid, vld_m);
    @(negedge clk);
    chk("pulse_low", pulse, 0);
  endtask

  task automatic pulse_snap_rel(bit s, bit r);
    @(negedge clk);
    snap = s;
    rel  = r;
    @(negedge clk);
    snap = 1'b0;
    rel  = 1'b0;
  endtask

  int r, c;

  initial begin
    model_reset();
    idle(3);
    reset = 1'b0;
    chk("rst_freeze", freeze, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_count", fcnt, 0);
    chk("rst_valid", valid, 0);
    chk("rst_row", crow, 0);
    chk("rst_col", ccol, 0);
    chk("rst_crlow", crl, 140);
    chk("rst_crhigh", crh, 255);
    chk("rst_cblow", cbl, 0);
    chk("rst_cbhigh", cbh, 120);

    for (int i = 0; i < 3; i++) begin
      frame_begin();
      idle($urandom_range(4, 12));
      frame_finish(0, 0, 0, 0, 0);
      idle($urandom_range(2, 6));
    end
    chk("three_frames", fcnt, 3);
    chk("three_pulses", pulses_seen, 3);
    chk("live_freeze", freeze, 0);

    // Snapshot: arm mid-frame, capture next, release later.
    frame_begin();
    idle(3);
    pulse_snap_rel(1, 0);
    chk("armed_busy", busy, 1);
    chk("armed_freeze", freeze, 0);
    frame_finish(0, 0, 0, 0, 0);
    chk("armed_hold", busy, 1);
    idle(2);
    frame_begin();
    chk("capture_busy", busy, 1);
    chk("capture_freeze", freeze, 0);
    idle(4);
    frame_finish(0, 0, 0, 0, 0);
    chk("frozen_freeze", freeze, 1);
    chk("frozen_busy", busy, 0);
    idle(2);
    frame_begin();
    idle(2);
    pulse_snap_rel(0, 1);
    chk("rel_pending", freeze, 1);
    frame_finish(0, 0, 0, 0, 0);
    chk("rel_wait_end", freeze, 1);
    idle(3);
    chk("rel_wait_blank", freeze, 1);
    frame_begin();
    chk("released", freeze, 0);
    chk("released_busy", busy, 0);
    frame_finish(0, 0, 0, 0, 0);

    // Thresholds change only at frame end.
    frame_begin();
    thr_write(0, 100);
    idle(2);
    chk("crlow_shadowed", crl, 140);
    frame_finish(0, 0, 0, 0, 0);
    chk("crlow_100", crl, 100);
    frame_begin();
    idle(3);
    frame_finish(0, 0, 1, 0, 90);
    chk("crlow_still_100", crl, 100);
    frame_begin();
    idle(3);
    frame_finish(0, 0, 0, 0, 0);
    chk("crlow_90", crl, 90);

    // Centre qualification from a fresh reset.
    do_reset();
    frame_begin();
    frame_finish(200, 300, 0, 0, 0);
    chk("c1_valid", valid, 1);
    frame_begin();
    frame_finish(210, 310, 0, 0, 0);
    chk("c2_valid", valid, 1);
    frame_begin();
    frame_finish(400, 310, 0, 0, 0);
    chk("c3_jump", valid, 0);
    chk("c3_row", crow, 400);
    frame_begin();
    frame_finish(420, 650, 0, 0, 0);
    frame_begin();
    frame_finish(430, 700, 0, 0, 0);
    chk("c5_colbound", valid, 0);

    // Randomized frames: centres and threshold writes.
    for (int i = 0; i < 24; i++) begin
      frame_begin();
      if ($urandom_range(0, 1) == 1)
        thr_write($urandom_range(0, 3), $urandom_range(0, 255));
      idle($urandom_range(1, 5));
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 1000);
        c = $urandom_range(0, 1000);
      end else begin
        r = prow_m + $urandom_range(0, 140) - 70;
        c = pcol_m + $urandom_range(0, 140) - 70;
        if (r < 0) r = 0;
        if (c < 0) c = 0;
      end
      frame_finish(r, c, $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 255));
      idle($urandom_range(1, 4));
    end

    // Reset in CAPTURE returns to LIVE immediately.
    pulse_snap_rel(1, 0);
    frame_begin();
    chk("cap_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    vreq  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rcap_busy", busy, 0);
    chk("rcap_freeze", freeze, 0);
    chk("rcap_count", fcnt, 0);
    chk("rcap_crlow", crl, 140);
    idle(2);
    chk("rcap_nopulse", pulse, 0);

    // Snap and release together while frozen.
    pulse_snap_rel(1, 0);
    frame_begin();
    frame_finish(10, 10, 0, 0, 0);
    chk("f2_frozen", freeze, 1);
    pulse_snap_rel(1, 1);
    chk("both_busy", busy, 0);
    chk("both_freeze", freeze, 1);
    frame_begin();
    chk("both_released", freeze, 0);
    chk("both_live", busy, 0);
    frame_finish(12, 12, 0, 0, 0);
    chk("stay_live", busy, 0);
    idle(2);
    chk("pulse_total", pulses_seen, pulses_m);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
